// File: rtl/compfloat_pkg.sv
// Shared opcode encoding and per-operand class record for the float comparator.
package compfloat_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_EQ   = 3'd0;
  localparam logic [OP_W-1:0] OP_LT   = 3'd1;
  localparam logic [OP_W-1:0] OP_LE   = 3'd2;
  localparam logic [OP_W-1:0] OP_GT   = 3'd3;
  localparam logic [OP_W-1:0] OP_GE   = 3'd4;
  localparam logic [OP_W-1:0] OP_NE   = 3'd5;
  localparam logic [OP_W-1:0] OP_UN   = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
    logic sign;
  } cls_t;

endpackage

// File: rtl/compfloat_if.sv
// Transaction bus of the float comparator: operands/opcode in, result/unordered out.
// COMPFLOAT_INVALID_EN adds the invalid flag to the output side.
interface compfloat_if import compfloat_pkg::*; #(parameter int W = 32) ();

  logic            in_valid;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [OP_W-1:0] op;
  logic            out_valid;
  logic            result;
  logic            unordered;

`ifdef COMPFLOAT_INVALID_EN
  logic            invalid;

  modport master (output in_valid, a, b, op, input out_valid, result, unordered, invalid);
  modport slave  (input in_valid, a, b, op, output out_valid, result, unordered, invalid);
`else
  modport master (output in_valid, a, b, op, input out_valid, result, unordered);
  modport slave  (input in_valid, a, b, op, output out_valid, result, unordered);
`endif

endinterface

// File: rtl/compfloat_classify.sv
// Combinational class decode of one IEEE-754-style operand (NaN, sNaN, zero, sign).
// Zero latency; no flow control.
module compfloat_classify import compfloat_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output cls_t                 cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = x[EXP_W+MAN_W-1:MAN_W];
  assign man_f = x[MAN_W-1:0];

  assign cls.is_nan  = (&exp_f) && (|man_f);
  // Quiet NaNs carry the mantissa MSB set; anything else in the NaN space signals.
  assign cls.is_snan = cls.is_nan && !man_f[MAN_W-1];
  assign cls.is_zero = !(|exp_f) && !(|man_f);
  assign cls.sign    = x[EXP_W+MAN_W];

endmodule

// File: rtl/compfloat_multi.sv
// Multi-opcode float comparator: LATENCY ce-enabled cycles, one transaction per enabled cycle.
// No backpressure; ce=0 freezes every stage. COMPFLOAT_INVALID_EN adds the invalid output.
module compfloat_multi import compfloat_pkg::*; #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  compfloat_if.slave  io
);

  localparam int W = 1 + EXP_W + MAN_W;

  if (LATENCY < 2 || LATENCY > 6) begin : g_bad_latency
    $fatal(1, "compfloat_multi: LATENCY must be within 2..6");
  end

  cls_t cls_a, cls_b;

  compfloat_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(io.a), .cls(cls_a));
  compfloat_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(io.b), .cls(cls_b));

  logic            s1_vld;
  logic [OP_W-1:0] s1_op;
  cls_t            s1_ca, s1_cb;
  logic            s1_mag_lt, s1_mag_eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_op     <= '0;
      s1_ca     <= '0;
      s1_cb     <= '0;
      s1_mag_lt <= 1'b0;
      s1_mag_eq <= 1'b0;
    end else if (ce) begin
      s1_vld <= io.in_valid;
      if (io.in_valid) begin
        s1_op     <= io.op;
        s1_ca     <= cls_a;
        s1_cb     <= cls_b;
        s1_mag_lt <= io.a[W-2:0] <  io.b[W-2:0];
        s1_mag_eq <= io.a[W-2:0] == io.b[W-2:0];
      end
    end
  end

  logic both_zero, any_nan, lt, eq, res2;

  always_comb begin
    both_zero = s1_ca.is_zero && s1_cb.is_zero;
    any_nan   = s1_ca.is_nan || s1_cb.is_nan;
    lt        = 1'b0;
    eq        = 1'b0;
    if (both_zero) begin
      eq = 1'b1;
    end else if (s1_ca.sign != s1_cb.sign) begin
      lt = s1_ca.sign;
    end else begin
      // Sign-magnitude: for negatives the larger magnitude is the smaller value.
      eq = s1_mag_eq;
      lt = s1_ca.sign ? (!s1_mag_lt && !s1_mag_eq) : s1_mag_lt;
    end

    res2 = 1'b0;
    if (any_nan) begin
      res2 = (s1_op == OP_NE) || (s1_op == OP_UN);
    end else begin
      case (s1_op)
        OP_EQ:   res2 = eq;
        OP_LT:   res2 = lt;
        OP_LE:   res2 = lt || eq;
        OP_GT:   res2 = !lt && !eq;
        OP_GE:   res2 = !lt;
        OP_NE:   res2 = !eq;
        default: res2 = 1'b0;
      endcase
    end
  end

`ifdef COMPFLOAT_INVALID_EN
  logic inv2;
  assign inv2 = s1_ca.is_snan || s1_cb.is_snan ||
                (any_nan && (s1_op >= OP_LT) && (s1_op <= OP_GE));
  logic pinv [2:LATENCY];
`else
  logic unused_snan;
  assign unused_snan = s1_ca.is_snan | s1_cb.is_snan;
`endif

  // Stage 2 onward; payload only moves with a valid so outputs hold across bubbles.
  logic pv   [2:LATENCY];
  logic pres [2:LATENCY];
  logic pun  [2:LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 2; k <= LATENCY; k++) begin
        pv[k]   <= 1'b0;
        pres[k] <= 1'b0;
        pun[k]  <= 1'b0;
`ifdef COMPFLOAT_INVALID_EN
        pinv[k] <= 1'b0;
`endif
      end
    end else if (ce) begin
      pv[2] <= s1_vld;
      if (s1_vld) begin
        pres[2] <= res2;
        pun[2]  <= any_nan;
`ifdef COMPFLOAT_INVALID_EN
        pinv[2] <= inv2;
`endif
      end
      for (int k = 3; k <= LATENCY; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) begin
          pres[k] <= pres[k-1];
          pun[k]  <= pun[k-1];
`ifdef COMPFLOAT_INVALID_EN
          pinv[k] <= pinv[k-1];
`endif
        end
      end
    end
  end

  assign io.out_valid = pv[LATENCY];
  assign io.result    = pres[LATENCY];
  assign io.unordered = pun[LATENCY];
`ifdef COMPFLOAT_INVALID_EN
  assign io.invalid   = pinv[LATENCY];
`endif

endmodule

// File: tb/tb_compfloat_multi.sv
// Scoreboard bench: single precision at LATENCY=2 and double precision at LATENCY=4.
module tb_compfloat_multi;
  import compfloat_pkg::*;

  localparam int LAT32 = 2;
  localparam int LAT64 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32, ce32, rst64, ce64;

  compfloat_if #(.W(32)) if32 ();
  compfloat_if #(.W(64)) if64 ();

  compfloat_multi #(.EXP_W(8), .MAN_W(23), .LATENCY(LAT32)) dut32 (
    .clk(clk), .rst(rst32), .ce(ce32), .io(if32)
  );
  compfloat_multi #(.EXP_W(11), .MAN_W(52), .LATENCY(LAT64)) dut64 (
    .clk(clk), .rst(rst64), .ce(ce64), .io(if64)
  );

  typedef struct packed {
    logic        res;
    logic        un;
    logic        inv;
    logic [15:0] id;
  } exp_t;

  exp_t q32[$], q64[$];
  int   acc32[$], acc64[$];
  int   n_cmp = 0, n_err = 0;
  int   cnt32 = 0, cnt64 = 0, n_out64 = 0, id_ctr = 0;
  exp_t last32, e32, e64;
  bit   have_last32 = 0;
  logic m32_r, m32_en, m64_r, m64_en;
  int   a32, a64;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s id=%0d got=%0h want=%0h", name, id, act, want);
    end
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic res, input logic un, input logic inv);
    exp_t e;
    @(posedge clk); #1;
    ce32 = 1'b1; if32.in_valid = 1'b1; if32.a = a; if32.b = b; if32.op = op;
    e.res = res; e.un = un; e.inv = inv; e.id = 16'(id_ctr);
    q32.push_back(e);
    id_ctr++;
  endtask

  task automatic idle32(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ce32 = 1'b1; if32.in_valid = 1'b0;
    end
  endtask

  function automatic logic is_nan64(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // Reference built on native double comparisons rather than bit fields.
  function automatic logic [2:0] ref64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    real  ra, rb;
    logic un, res, inv;
    ra  = $bitstoreal(a);
    rb  = $bitstoreal(b);
    un  = is_nan64(a) || is_nan64(b);
    case (op)
      3'd0: res = (ra == rb);
      3'd1: res = (ra <  rb);
      3'd2: res = (ra <= rb);
      3'd3: res = (ra >  rb);
      3'd4: res = (ra >= rb);
      3'd5: res = !(ra == rb);
      default: res = 1'b0;
    endcase
    if (un) res = (op == 3'd5) || (op == 3'd6);
    inv = (is_nan64(a) && !a[51]) || (is_nan64(b) && !b[51]) || (un && op >= 3'd1 && op <= 3'd4);
    return {res, un, inv};
  endfunction

  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    exp_t e;
    logic [2:0] r;
    r = ref64(a, b, op);
    @(posedge clk); #1;
    ce64 = 1'b1; if64.in_valid = 1'b1; if64.a = a; if64.b = b; if64.op = op;
    e.res = r[2]; e.un = r[1]; e.inv = r[0]; e.id = 16'(id_ctr);
    q64.push_back(e);
    id_ctr++;
  endtask

  task automatic idle64(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ce64 = 1'b1; if64.in_valid = 1'b0;
    end
  endtask

  // Single-precision monitor: pops on each fresh output, checks latency and stall freeze.
  initial forever begin
    @(posedge clk);
    m32_r  = rst32;
    m32_en = ce32 && !rst32;
    if (m32_r) begin q32.delete(); acc32.delete(); have_last32 = 0; end
    if (m32_en) begin
      if (if32.in_valid) acc32.push_back(cnt32);
      cnt32++;
    end
    #3;
    if (m32_r) begin
      chk("rst_vld32", -1, if32.out_valid, 0);
      chk("rst_res32", -1, if32.result, 0);
      chk("rst_un32", -1, if32.unordered, 0);
    end else if (m32_en && if32.out_valid === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL extra32 got=unexpected output want=none");
      end else begin
        e32 = q32.pop_front();
        a32 = acc32.pop_front();
        chk("res32", int'(e32.id), if32.result, e32.res);
        chk("un32", int'(e32.id), if32.unordered, e32.un);
`ifdef COMPFLOAT_INVALID_EN
        chk("inv32", int'(e32.id), if32.invalid, e32.inv);
`endif
        chk("lat32", int'(e32.id), cnt32 - a32, LAT32);
        last32 = e32; have_last32 = 1;
      end
    end else if (!ce32 && have_last32 && if32.out_valid === 1'b1) begin
      chk("frz_res32", int'(last32.id), if32.result, last32.res);
      chk("frz_un32", int'(last32.id), if32.unordered, last32.un);
    end
  end

  initial forever begin
    @(posedge clk);
    m64_r  = rst64;
    m64_en = ce64 && !rst64;
    if (m64_r) begin q64.delete(); acc64.delete(); end
    if (m64_en) begin
      if (if64.in_valid) acc64.push_back(cnt64);
      cnt64++;
    end
    #3;
    if (m64_r) begin
      chk("rst_vld64", -1, if64.out_valid, 0);
    end else if (m64_en && if64.out_valid === 1'b1) begin
      n_out64++;
      if (q64.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL extra64 got=unexpected output want=none");
      end else begin
        e64 = q64.pop_front();
        a64 = acc64.pop_front();
        chk("res64", int'(e64.id), if64.result, e64.res);
        chk("un64", int'(e64.id), if64.unordered, e64.un);
`ifdef COMPFLOAT_INVALID_EN
        chk("inv64", int'(e64.id), if64.invalid, e64.inv);
`endif
        chk("lat64", int'(e64.id), cnt64 - a64, LAT64);
      end
    end
  end

  logic [63:0] pa [8];
  logic [63:0] pb [8];
  int          base;

  initial begin
    rst32 = 1'b1; ce32 = 1'b1; if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.op = '0;
    rst64 = 1'b1; ce64 = 1'b1; if64.in_valid = 1'b0; if64.a = '0; if64.b = '0; if64.op = '0;
    repeat (3) @(posedge clk);
    #1; rst32 = 1'b0; rst64 = 1'b0;

    // Single-precision directed vectors: {res, unordered, invalid} computed by hand.
    send32(32'h3F800000, 32'h40000000, OP_LT,   1, 0, 0);
    send32(32'h80000000, 32'h00000000, OP_EQ,   1, 0, 0);
    send32(32'h80000000, 32'h00000000, OP_LT,   0, 0, 0);
    send32(32'h80000000, 32'h00000000, OP_LE,   1, 0, 0);
    send32(32'h80000000, 32'h00000000, OP_NE,   0, 0, 0);
    send32(32'hC0000000, 32'hBF800000, OP_LT,   1, 0, 0);
    send32(32'hFF800000, 32'h7F800000, OP_GE,   0, 0, 0);
    send32(32'h7F800000, 32'h7F800000, OP_GE,   1, 0, 0);
    send32(32'h7FC00000, 32'h3F800000, OP_LT,   0, 1, 1);
    send32(32'h7FC00000, 32'h3F800000, OP_EQ,   0, 1, 0);
    send32(32'h7FC00000, 32'h3F800000, OP_GE,   0, 1, 1);
    send32(32'h7FC00000, 32'h3F800000, OP_NE,   1, 1, 0);
    send32(32'h7FC00000, 32'h3F800000, OP_UN,   1, 1, 0);
    send32(32'h7F800001, 32'h3F800000, OP_EQ,   0, 1, 1);
    send32(32'h7FC00000, 32'h3F800000, OP_RSVD, 0, 1, 0);
    send32(32'h3F800000, 32'h40000000, OP_RSVD, 0, 0, 0);
    send32(32'h3F800000, 32'h40000000, OP_UN,   0, 0, 0);
    send32(32'h00000001, 32'h00000002, OP_LT,   1, 0, 0);
    send32(32'h00000001, 32'h00000000, OP_GT,   1, 0, 0);
    send32(32'h80000001, 32'h00000000, OP_LT,   1, 0, 0);
    idle32(5);

    // Back-to-back stream with a 3-cycle ce stall; junk in_valid during the stall must be ignored.
    send32(32'h3F800000, 32'h40000000, OP_LT, 1, 0, 0);
    send32(32'h40000000, 32'h3F800000, OP_LT, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ce32 = 1'b0; if32.in_valid = 1'b1; if32.a = 32'h7FC00000; if32.b = 32'h0; if32.op = OP_NE;
    end
    send32(32'h3F800000, 32'h3F800000, OP_EQ, 1, 0, 0);
    send32(32'h3F800000, 32'h40000000, OP_GT, 0, 0, 0);
    idle32(6);

    // Double precision: three in flight, then reset before any can emerge.
    send64(64'h3FF0000000000000, 64'h4000000000000000, OP_LT);
    send64(64'h4000000000000000, 64'h3FF0000000000000, OP_GT);
    send64(64'h3FF0000000000000, 64'h3FF0000000000000, OP_EQ);
    @(posedge clk); #1;
    if64.in_valid = 1'b0; rst64 = 1'b1;
    @(posedge clk); #1;
    rst64 = 1'b0;
    base = n_out64;
    idle64(8);
    chk("noemerge64", -1, n_out64, base);

    pa[0] = 64'h3FF0000000000000; pb[0] = 64'h4000000000000000;
    pa[1] = 64'h8000000000000000; pb[1] = 64'h0000000000000000;
    pa[2] = 64'hC000000000000000; pb[2] = 64'hBFF0000000000000;
    pa[3] = 64'hFFF0000000000000; pb[3] = 64'h7FF0000000000000;
    pa[4] = 64'h7FF8000000000000; pb[4] = 64'h3FF0000000000000;
    pa[5] = 64'h0000000000000001; pb[5] = 64'h0000000000000002;
    pa[6] = 64'h4000000000000000; pb[6] = 64'h4000000000000000;
    pa[7] = 64'h7FF0000000000001; pb[7] = 64'h3FF0000000000000;
    base = n_out64;
    for (int p = 0; p < 8; p++)
      for (int o = 0; o < 8; o++)
        send64(pa[p], pb[p], 3'(o));
    idle64(10);
    chk("count64", -1, n_out64 - base, 64);

    chk("drain32", -1, q32.size(), 0);
    chk("drain64", -1, q64.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/compfloat_multi.md
Name: compfloat_multi

Overview:
- Parametrised native-RTL floating-point comparator; successor to the single-mode vendor-IP LT comparator.
- Takes two IEEE-754-style operands of configurable exponent/mantissa width and a per-transaction compare opcode.
- Produces a 1-bit result plus an unordered flag through a fixed-latency, ce-gated pipeline with valid tracking.
- Sits beside the other float arithmetic wrappers and feeds branch/select logic in the datapath.

Parameters:
- EXP_W, 8: exponent width in bits.
- MAN_W, 23: mantissa (fraction) width in bits. Operand width W = 1+EXP_W+MAN_W.
- LATENCY, 2: cycles from accepted input to output. Legal range is 2..6; values outside this range are a fatal elaboration error.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- ce, input, 1: clock enable; when low, the whole pipeline holds.
- in_valid, input, 1: a/b/op carry a transaction this cycle.
- a, input, W: operand A.
- b, input, W: operand B.
- op, input, 3: compare opcode. 0 EQ, 1 LT, 2 LE, 3 GT, 4 GE, 5 NE, 6 UN, 7 reserved.
- out_valid, output, 1: result/unordered are valid this cycle.
- result, output, 1: outcome of (a op b).
- unordered, output, 1: at least one operand is NaN.

Behaviour:
- Reset:
  - rst high at a clock edge clears every pipeline register, including valid bits; out_valid=0, result=0, unordered=0 the next cycle.
  - rst has priority over ce.
  - Reset mid-operation discards all in-flight transactions; none emerge afterwards.
- ce:
  - ce=0: no register changes, outputs hold their values, and in_valid is ignored.
  - ce=1: the pipeline advances one stage.
- Latency and throughput:
  - A transaction accepted (ce=1, in_valid=1) at edge N appears with out_valid=1 after exactly LATENCY ce-enabled edges.
  - Throughput is one transaction per enabled cycle. There is no backpressure.
- Stage 1 (registered) performs class decode per operand:
  - NaN: exp all-ones, mantissa ≠ 0.
  - Zero: exp = 0, mantissa = 0.
  - Sign bit.
  - Magnitude compare of {exp,mantissa} as an unsigned (W-1)-bit value, giving mag_lt and mag_eq.
  - op is carried alongside.
- Stage 2 combines the decoded values:
  - Both zero → equal, regardless of sign (+0 == -0).
  - Signs differ, not both zero → the negative operand is less.
  - Both positive → lt = mag_lt.
  - Both negative → lt = !mag_lt && !mag_eq.
  - Equal = mag_eq && signs equal, or both zero.
  - Infinities order naturally through the magnitude compare.
  - Denormals are compared exactly, with no flushing.
- NaN handling: if either operand is NaN, then unordered=1; EQ/LT/LE/GT/GE give 0, NE gives 1, UN gives 1.
- Non-NaN operands: unordered=0 and UN gives 0.
- Opcode 7 gives result=0, with unordered still reported.
- Stages 3..LATENCY are pure delay registers on {valid, result, unordered}.
- When out_valid=0, result and unordered hold their last values; the bench must not check them then.

Optional Feature:
- Macro COMPFLOAT_INVALID_EN adds output port invalid (1 bit), aligned with out_valid.
- invalid=1 when either operand is a signalling NaN (exp all-ones, mantissa MSB=0, mantissa≠0).
- invalid=1 also when any of LT/LE/GT/GE sees any NaN (IEEE signalling-compare rule).
- invalid resets to 0.
- Without the macro, the port and its logic are absent and all other behaviour is identical.

Decomposition:
- Package compfloat_pkg holds:
  - the opcode constants OP_EQ..OP_UN and OP_RSVD;
  - the 3-bit op width constant;
  - a class-record typedef {is_nan, is_snan, is_zero, sign}.
- Sub-module compfloat_classify (combinational, parametrised by EXP_W/MAN_W) decodes one operand. It is instantiated twice in stage 1.

Test Plan:
- Reset/latency: LATENCY=2, rst held 3 cycles then released; a=0x3F800000 (1.0), b=0x40000000 (2.0), op=LT, ce=1 → out_valid=1 with result=1, unordered=0, exactly 2 cycles after acceptance; out_valid=0 while rst is high.
- Signed zero: a=0x80000000, b=0x00000000; op=EQ → result=1; op=LT → 0; op=LE → 1; op=NE → 0.
- Negatives and infinities:
  - a=0xC0000000 (-2), b=0xBF800000 (-1), op=LT → 1.
  - a=0xFF800000 (-inf), b=0x7F800000 (+inf), op=GE → 0.
  - a=b=0x7F800000, op=GE → 1.
- NaN: a=0x7FC00000, b=0x3F800000.
  - op=LT/EQ/GE → result=0, unordered=1.
  - op=NE → result=1.
  - op=UN → result=1.
  - With COMPFLOAT_INVALID_EN: op=LT gives invalid=1; a=0x7F800001, op=EQ gives invalid=1.
- ce stall and back-to-back:
  - Stream 4 transactions on consecutive cycles; deassert ce for 3 cycles mid-stream.
  - Required: results arrive in order with no drops or duplicates, and outputs are frozen during the stall.
- Reset mid-flight and width: LATENCY=4; assert rst with 3 transactions in flight → none emerge after reset. Repeat the opcode sweep with EXP_W=11, MAN_W=52 (double) against a reference model.
